// File: rtl/sel_arb_pkg.sv
// Shared types and helpers for the selector-sharing arbiter.
// Round-robin arbitration is enabled by defining SEL_ARB_RR_EN.
package sel_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] onehot(input int idx);
    return 32'd1 << idx;
  endfunction

  function automatic int encode(input logic [31:0] vec);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (vec[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/sel_arb_pick.sv
// Combinational masked picker: first set bit of req & ~mask, searching upward from base.
// base is driven with zero when SEL_ARB_RR_EN is not defined.
module sel_arb_pick
  import sel_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IDX_W-1:0]   base,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any
);

  logic [NUM_REQ-1:0] cand;
  int                 pos;

  always_comb begin
    cand       = req & ~mask;
    win_onehot = '0;
    win_idx    = '0;
    any        = 1'b0;
    pos        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = (int'(base) + i) % NUM_REQ;
      if (!any && cand[pos]) begin
        any        = 1'b1;
        win_idx    = IDX_W'(pos);
        win_onehot = NUM_REQ'(onehot(pos));
      end
    end
  end

endmodule

// File: rtl/sel_share_arbiter.sv
// Shares one registered output among NUM_REQ requesters with hold-until-release grants
// and an optional hold-time preemption. Define SEL_ARB_RR_EN for round-robin arbitration.
module sel_share_arbiter
  import sel_arb_pkg::*;
#(
  parameter int                NUM_REQ     = 2,
  parameter int                DATA_W      = 4,
  parameter logic [DATA_W-1:0] DEFAULT_VAL = DATA_W'(4'h4),
  parameter int                MAX_HOLD    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      gnt_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      timeout
);

  localparam int IDX_W  = idx_w(NUM_REQ);
  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [NUM_REQ-1:0]  mask;
  logic [IDX_W-1:0]    base;
  logic [NUM_REQ-1:0]  win_onehot;
  logic [IDX_W-1:0]    win_idx;
  logic                any;
  logic [IDX_W-1:0]    owner;
  logic                hold_last;
  logic [DATA_W-1:0]   data_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // gnt is one-hot while BUSY, so the owner index is recovered from it directly.
  assign owner     = IDX_W'(encode(32'(gnt)));
  assign hold_last = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));

`ifdef SEL_ARB_RR_EN
  logic [IDX_W-1:0] rr_ptr;
  assign base = rr_ptr;
`else
  assign base = '0;
`endif

  sel_arb_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req       (req),
    .mask      (mask),
    .base      (base),
    .win_onehot(win_onehot),
    .win_idx   (win_idx),
    .any       (any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      out_data  <= DEFAULT_VAL;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
      mask      <= '0;
`ifdef SEL_ARB_RR_EN
      rr_ptr    <= '0;
`endif
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          out_data <= DEFAULT_VAL;
          mask     <= '0;
          if (any) begin
            gnt       <= win_onehot;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
            state     <= BUSY;
`ifdef SEL_ARB_RR_EN
            rr_ptr    <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif
          end
        end
        BUSY: begin
          out_data <= data_arr[owner];
          if (!req[owner]) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            state     <= IDLE;
          end else if (hold_last) begin
            // Preempted owner sits out exactly one arbitration.
            gnt       <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b1;
            mask      <= gnt;
            state     <= IDLE;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sel_share_arbiter.sv
// Self-checking bench for sel_share_arbiter: directed scenarios plus randomized traffic
// compared against an index-based behavioural model.
module tb_sel_share_arbiter;

  localparam int NREQ     = 2;
  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = '0;
  logic [7:0] req_data = '0;
  logic [1:0] gnt;
  logic       gnt_valid;
  logic [3:0] out_data;
  logic       timeout;

  int pass_cnt = 0;
  int total_cnt = 0;

  sel_share_arbiter #(
    .NUM_REQ    (2),
    .DATA_W     (4),
    .DEFAULT_VAL(4'h4),
    .MAX_HOLD   (MAX_HOLD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .out_data (out_data),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  // Behavioural model: owner index (-1 = nobody), cycles owned, excluded index, rr start.
  int         m_owner, m_cnt, m_mask, m_ptr, m_w, m_c, m_start;
  logic [3:0] m_out;
  logic       m_to;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_cnt = 0; m_mask = -1; m_ptr = 0; m_out = 4'h4; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        m_out = 4'h4;
        m_w = -1;
`ifdef SEL_ARB_RR_EN
        m_start = m_ptr;
`else
        m_start = 0;
`endif
        for (int k = 0; k < NREQ; k++) begin
          m_c = (m_start + k) % NREQ;
          if (m_w < 0 && req[m_c] && m_c != m_mask) m_w = m_c;
        end
        m_mask = -1;
        if (m_w >= 0) begin
          m_owner = m_w; m_cnt = 0; m_ptr = (m_w + 1) % NREQ;
        end
      end else begin
        m_out = req_data[m_owner*4 +: 4];
        if (!req[m_owner]) m_owner = -1;
        else if (MAX_HOLD != 0 && m_cnt == MAX_HOLD - 1) begin
          m_mask = m_owner; m_owner = -1; m_to = 1'b1;
        end else m_cnt++;
      end
    end
  end

  function automatic logic [7:0] exp_vec();
    logic [7:0] e;
    e[7:6] = (m_owner >= 0) ? 2'(1 << m_owner) : 2'b00;
    e[5]   = (m_owner >= 0);
    e[4:1] = m_out;
    e[0]   = m_to;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    total_cnt++;
    if ({gnt, gnt_valid, out_data, timeout} !== 8'b00_0_0100_0) $display("FAIL reset_hold got=%b want=%b", {gnt, gnt_valid, out_data, timeout}, 8'b00_0_0100_0);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
    total_cnt++;
    if ({gnt, gnt_valid, out_data, timeout} !== 8'b00_0_0100_0) $display("FAIL reset_release got=%b want=%b", {gnt, gnt_valid, out_data, timeout}, 8'b00_0_0100_0);
    else pass_cnt++;
    $display("test_reset: done");
  endtask

  task automatic test_simultaneous();
    req = 2'b11; req_data = {4'hf, 4'h5};
    tick();
    total_cnt++;
    if ({gnt, gnt_valid, out_data} !== {2'b01, 1'b1, 4'h4}) $display("FAIL simul_gnt got=%b want=%b", {gnt, gnt_valid, out_data}, {2'b01, 1'b1, 4'h4});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({gnt, out_data} !== {2'b01, 4'h5}) $display("FAIL simul_data got=%b want=%b", {gnt, out_data}, {2'b01, 4'h5});
    else pass_cnt++;
    $display("test_simultaneous: gnt=%b out_data=%h", gnt, out_data);
  endtask

  task automatic test_release();
    req = 2'b10;
    tick();
    total_cnt++;
    if ({gnt, gnt_valid, timeout} !== 4'b00_0_0) $display("FAIL release_idle got=%b want=%b", {gnt, gnt_valid, timeout}, 4'b0000);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({gnt, out_data} !== {2'b10, 4'h4}) $display("FAIL release_next_gnt got=%b want=%b", {gnt, out_data}, {2'b10, 4'h4});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({gnt, out_data} !== {2'b10, 4'hf}) $display("FAIL release_next_data got=%b want=%b", {gnt, out_data}, {2'b10, 4'hf});
    else pass_cnt++;
    req = 2'b00;
    tick(); tick();
    $display("test_release: gnt=%b", gnt);
  endtask

  task automatic test_preempt();
    int seen;
    req = 2'b11; req_data = {4'h3, 4'ha};
    tick();
    total_cnt++;
    if (gnt !== 2'b01) $display("FAIL preempt_first_gnt got=%b want=%b", gnt, 2'b01);
    else pass_cnt++;
    seen = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (timeout === 1'b1) begin seen = n; break; end
    end
    // Owned cycles: the grant edge plus 7 counting edges, then the preempting edge.
    total_cnt++;
    if (seen !== 8 || gnt !== 2'b00) $display("FAIL preempt_timeout cycles=%0d gnt=%b want cycles=8 gnt=00", seen, gnt);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({gnt, timeout} !== {2'b10, 1'b0}) $display("FAIL preempt_handover got=%b want=%b", {gnt, timeout}, 3'b100);
    else pass_cnt++;
    req = 2'b00;
    tick(); tick();
    // Sole masked requester: waits one IDLE cycle for the mask to clear, then wins.
    req = 2'b01;
    tick();
    for (int n = 0; n < 20 && timeout !== 1'b1; n++) tick();
    tick();
    total_cnt++;
    if ({gnt, exp_vec()} !== {2'b00, exp_vec()} || {gnt, gnt_valid, out_data, timeout} !== exp_vec()) $display("FAIL masked_wait got=%b want=%b", {gnt, gnt_valid, out_data, timeout}, exp_vec());
    else pass_cnt++;
    tick();
    total_cnt++;
    if (gnt !== 2'b01) $display("FAIL masked_regrant got=%b want=%b", gnt, 2'b01);
    else pass_cnt++;
    req = 2'b00;
    tick(); tick();
    $display("test_preempt: timeout after %0d owned cycles", seen);
  endtask

  task automatic test_rr();
    logic [1:0] want [3];
    logic [1:0] got;
`ifdef SEL_ARB_RR_EN
    want = '{2'b01, 2'b10, 2'b01};
`else
    want = '{2'b01, 2'b01, 2'b01};
`endif
    req = 2'b11;
    for (int g = 0; g < 3; g++) begin
      for (int n = 0; n < 10 && gnt_valid !== 1'b1; n++) tick();
      got = gnt;
      total_cnt++;
      if (got !== want[g]) $display("FAIL rr_grant%0d got=%b want=%b", g, got, want[g]);
      else pass_cnt++;
      tick();
      req = 2'b11 & ~got;
      tick();
      for (int n = 0; n < 5 && gnt_valid !== 1'b0; n++) tick();
      req = 2'b11;
    end
    req = 2'b00;
    tick(); tick();
    $display("test_rr: sequence done");
  endtask

  task automatic test_idle();
    req = 2'b00;
    for (int n = 0; n < 10; n++) begin
      tick();
      total_cnt++;
      if ({gnt, gnt_valid, out_data, timeout} !== 8'b00_0_0100_0) $display("FAIL idle_cycle%0d got=%b want=%b", n, {gnt, gnt_valid, out_data, timeout}, 8'b00_0_0100_0);
      else pass_cnt++;
    end
    $display("test_idle: 10 cycles idle");
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 3) req = 2'($urandom_range(0, 3));
      req_data = 8'($urandom);
      tick();
      total_cnt++;
      if ({gnt, gnt_valid, out_data, timeout} !== exp_vec() || !$onehot0(gnt)) begin
        $display("FAIL random_cycle%0d got=%b want=%b", n, {gnt, gnt_valid, out_data, timeout}, exp_vec());
        errs++;
      end else pass_cnt++;
    end
    req = 2'b00;
    tick(); tick();
    $display("test_random: 400 cycles, %0d mismatching", errs);
  endtask

  task automatic test_async_reset();
    req = 2'b01; req_data = {4'h2, 4'h9};
    tick(); tick();
    total_cnt++;
    if ({gnt, out_data} !== {2'b01, 4'h9}) $display("FAIL async_setup got=%b want=%b", {gnt, out_data}, {2'b01, 4'h9});
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({gnt, gnt_valid, out_data, timeout} !== 8'b00_0_0100_0) $display("FAIL async_reset got=%b want=%b", {gnt, gnt_valid, out_data, timeout}, 8'b00_0_0100_0);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1; req = 2'b00;
    tick();
    total_cnt++;
    if ({gnt, gnt_valid, out_data, timeout} !== exp_vec()) $display("FAIL async_after got=%b want=%b", {gnt, gnt_valid, out_data, timeout}, exp_vec());
    else pass_cnt++;
    $display("test_async_reset: done");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_simultaneous();
    test_release();
    test_preempt();
    test_rr();
    test_idle();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
